memoria_port_arbiter: RTL and testbench
=======================================

// Module: memoria_port_arbiter
// PURPOSE
// - Round-robin arbiter sharing one port (port A) of the 64x8 dual-port RAM among N_REQ requesters.
// - Registers the winning request onto the RAM port and returns read data to the requester that
//   issued the read. One access per cycle, full throughput.
// - Port B is owned elsewhere. Same-address A/B write collisions are outside this block's scope.
// PARAMETERS
// - N_REQ   4  number of requesters (2..8)
// - DATA_W  8  RAM data width
// - ADDR_W  6  RAM address width
// PORTS
// - clk        in   1               single clock, all logic on posedge
// - rst_n      in   1               asynchronous, active-low reset
// - en         in   1               1 = arbitration enabled; 0 = no new grants
// - req        in   N_REQ           per-requester request level
// - req_we     in   N_REQ           per-requester write flag (1 = write, 0 = read)
// - req_addr   in   N_REQ*ADDR_W    packed addresses; requester i at [i*ADDR_W +: ADDR_W]
// - req_wdata  in   N_REQ*DATA_W    packed write data; requester i at [i*DATA_W +: DATA_W]
// - gnt        out  N_REQ           one-hot grant pulse, registered
// - rd_valid   out  N_REQ           one-hot read-return strobe
// - rd_data    out  DATA_W          read data; valid only while rd_valid != 0
// - mem_addr   out  ADDR_W          to RAM addr_a, registered
// - mem_wdata  out  DATA_W          to RAM data_a, registered
// - mem_we     out  1               to RAM we_a, registered
// - mem_q      in   DATA_W          from RAM q_a
// BEHAVIOUR
// - Reset (rst_n = 0, async): gnt, rd_valid, mem_we, mem_addr, mem_wdata all 0; rr_ptr = 0;
//   read-tag pipeline cleared.
// - Arbitration, at every posedge with en = 1 and req != 0:
//   - Winner w is the first set bit of req searching from rr_ptr upward, wrapping N_REQ-1 -> 0.
//   - Next cycle: gnt = 1<<w; mem_addr/mem_wdata/mem_we = req_addr[w]/req_wdata[w]/req_we[w].
//   - rr_ptr <= (w+1) mod N_REQ.
// - No-grant cycles: if req == 0 or en == 0, next cycle gnt = 0 and mem_we = 0. mem_addr and
//   mem_wdata hold their previous values. rr_ptr is unchanged.
// - Timing: request sampled at edge E0; gnt and RAM inputs valid cycle E0..E1; RAM samples at E1;
//   mem_q valid E1..E2.
// - Read return:
//   - A granted read (req_we[w] = 0) asserts rd_valid = 1<<w in the cycle after gnt, i.e. 2 cycles
//     after request sampling.
//   - rd_data = mem_q (combinational pass-through).
//   - Tag: 1-stage register holding {valid, w}, written on every grant edge.
// - Granted write: no rd_valid; gnt is the write acknowledge.
// - Handshake:
//   - Requester holds req/we/addr/wdata stable until it sees gnt.
//   - Deasserting req during the gnt cycle ends the transaction.
//   - Keeping req high during the gnt cycle is a new request for the next slot, competing normally.
// - Fairness: a continuously asserted req is granted within N_REQ grant cycles.
// - Back-to-back: reads from different requesters on consecutive cycles produce consecutive
//   rd_valid pulses, each tagged correctly.
// - en -> 0: stops new grants from the next edge. The grant already issued and its read return
//   still complete.
// - Reset mid-operation: any in-flight read return is dropped; no rd_valid after reset release
//   until a new grant.
// - Read-after-write, same requester or other requester, same address: the write's grant cycle
//   precedes the read's grant cycle, so the read returns the new data.
// TESTING
// - Reset: rst_n=0 with req=4'b1111 -> gnt=0, rd_valid=0, mem_we=0; first grant after release
//   goes to req 0.
// - Single write then read:
//   - req[1] writes addr 0x05, data 0xA5 -> gnt=4'b0010, mem_we=1, mem_addr=0x05.
//   - Read of 0x05 by req[1] -> rd_valid=4'b0010, rd_data=0xA5, two cycles after sampling.
// - All four requesting continuously -> grant order 0,1,2,3,0,1... with no bubbles. Each
//   requester reads its own pre-written address (0x10+i = 0x20+i); every rd_valid is tagged
//   with the right data.
// - Fairness with ptr at 2: req=4'b1011 -> grants 3, 0, 1, 3; req[2] raised mid-sequence is
//   granted within 4 grants.
// - Toggle en:
//   - en=0 for 3 cycles with req=4'b0001 -> gnt=0, mem_we=0 during those cycles.
//   - A read granted just before en fell still returns rd_valid.
// - Async reset asserted in the cycle after a read grant -> no rd_valid appears; rr_ptr=0 after
//   release.

Source files
------------

// File: rtl/memoria_port_arbiter.sv
// Round-robin arbiter that shares RAM port A among N_REQ requesters.
// It registers the winning request onto the RAM port and steers the
// synchronous read data back to the requester that issued the read.
module memoria_port_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_we,
    input  logic [DATA_W-1:0]        mem_q
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Round-robin pointer: first requester index searched this cycle
    logic [PTR_W-1:0]  rr_ptr;

    // Combinational winner selection
    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  cand;
    logic [N_REQ-1:0]  win_onehot;
    logic [PTR_W-1:0]  next_ptr;
    logic              grant_now;

    // Read-return tag: {valid, requester} of the grant issued on the last edge
    logic              tag_valid;
    logic [PTR_W-1:0]  tag_idx;
    logic [N_REQ-1:0]  tag_onehot;

    // Search req from rr_ptr upward with wrap; first set bit wins
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((32'(rr_ptr) + k) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Decode winner to one-hot and compute the pointer that follows it
    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
        if (win_idx == PTR_W'(N_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = win_idx + 1'b1;
        end
    end

    assign grant_now = en && win_found;

    // Grant register: drive the RAM port and record the read tag on each grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            rr_ptr    <= '0;
            tag_valid <= 1'b0;
            tag_idx   <= '0;
        end else if (grant_now) begin
            gnt       <= win_onehot;
            mem_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[win_idx*DATA_W +: DATA_W];
            mem_we    <= req_we[win_idx];
            rr_ptr    <= next_ptr;
            tag_valid <= ~req_we[win_idx];
            tag_idx   <= win_idx;
        end else begin
            // Address and write data hold; only the strobes drop
            gnt       <= '0;
            mem_we    <= 1'b0;
            tag_valid <= 1'b0;
        end
    end

    // Decode the stored tag to the requester it belongs to
    always_comb begin
        tag_onehot          = '0;
        tag_onehot[tag_idx] = 1'b1;
    end

    // Read-return strobe: lines up with mem_q, one cycle after the grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= '0;
        end else if (tag_valid) begin
            rd_valid <= tag_onehot;
        end else begin
            rd_valid <= '0;
        end
    end

    assign rd_data = mem_q;

endmodule

// File: tb/tb_memoria_port_arbiter.sv
// Directed bench for memoria_port_arbiter with a synchronous 64x8 RAM model on port A.
module tb_memoria_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  req;
    logic [3:0]  req_we;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt;
    logic [3:0]  rd_valid;
    logic [7:0]  rd_data;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_q;

    int n_assert;
    int n_fail;

    logic [7:0] ram [64];

    memoria_port_arbiter #(
        .N_REQ  (4),
        .DATA_W (8),
        .ADDR_W (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_q     (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 8'h00;
    end

    // Port-A RAM model: registered read (old data on a same-cycle write)
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_q <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [5:0] a, input logic [7:0] d);
        req[i]                = 1'b1;
        req_we[i]             = we;
        req_addr[i*6 +: 6]    = a;
        req_wdata[i*8 +: 8]   = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int seq_a [4];
        int seq_b [3];
        int prev;
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        en        = 1'b1;
        req       = 4'b1111;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset with every requester asserted
        tick();
        tick();
        chk("rst_gnt",      32'(gnt),      32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_mem_we",   32'(mem_we),   32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("first_gnt",    32'(gnt),      32'h1);
        chk("first_we",     32'(mem_we),   32'h0);
        req = '0;
        tick();
        chk("first_rdv",    32'(rd_valid), 32'h1);
        chk("first_rdd",    32'(rd_data),  32'h0);
        chk("first_idle",   32'(gnt),      32'h0);

        // Single write then read by requester 1 (pointer now 1)
        set_req(1, 1'b1, 6'h05, 8'hA5);
        tick();
        chk("wr_gnt",   32'(gnt),       32'h2);
        chk("wr_we",    32'(mem_we),    32'h1);
        chk("wr_addr",  32'(mem_addr),  32'h05);
        chk("wr_data",  32'(mem_wdata), 32'hA5);
        set_req(1, 1'b0, 6'h05, 8'h00);
        tick();
        chk("rd_gnt",   32'(gnt),       32'h2);
        chk("rd_we",    32'(mem_we),    32'h0);
        chk("wr_nordv", 32'(rd_valid),  32'h0);
        req = '0;
        tick();
        chk("rd_rdv",   32'(rd_valid),  32'h2);
        chk("rd_rdd",   32'(rd_data),   32'hA5);
        chk("rd_idle",  32'(gnt),       32'h0);

        // Pre-write 0x10+i = 0x20+i with all four requesting (pointer 2 -> order 2,3,0,1)
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'(8'h10 + i), 8'(8'h20 + i));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("pw_gnt",  32'(gnt),      32'(1) << ((2 + k) % 4));
            chk("pw_addr", 32'(mem_addr), 32'(32'h10 + (2 + k) % 4));
            chk("pw_we",   32'(mem_we),   32'h1);
        end
        // One more grant to requester 3 moves the pointer back to 0
        req = 4'b1000;
        tick();
        chk("pw3_gnt", 32'(gnt), 32'h8);

        // Continuous reads from all four: grant order 0,1,2,3,0,1,2,3 with tagged returns
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 6'(8'h10 + i), 8'h00);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_gnt",  32'(gnt),      32'(1) << (k % 4));
            chk("rr_addr", 32'(mem_addr), 32'(32'h10 + k % 4));
            if (k == 0) begin
                chk("rr_rdv0", 32'(rd_valid), 32'h0);
            end else begin
                chk("rr_rdv",  32'(rd_valid), 32'(1) << ((k - 1) % 4));
                chk("rr_rdd",  32'(rd_data),  32'(32'h20 + (k - 1) % 4));
            end
        end
        req = '0;
        tick();
        chk("rr_last_rdv", 32'(rd_valid), 32'h8);
        chk("rr_last_rdd", 32'(rd_data),  32'h23);
        chk("rr_idle",     32'(gnt),      32'h0);

        // Move pointer to 2 via a write by requester 1
        set_req(1, 1'b1, 6'h30, 8'h5A);
        tick();
        chk("ptr2_gnt", 32'(gnt), 32'h2);

        // Fairness: req=1011 from pointer 2 -> 3,0,1,3; then req[2] joins -> 0,1,2
        req = '0;
        set_req(0, 1'b0, 6'h10, 8'h00);
        set_req(1, 1'b0, 6'h11, 8'h00);
        set_req(3, 1'b0, 6'h13, 8'h00);
        seq_a = '{3, 0, 1, 3};
        prev  = -1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fair_gnt", 32'(gnt), 32'(1) << seq_a[k]);
            if (prev < 0) chk("fair_rdv0", 32'(rd_valid), 32'h0);
            else begin
                chk("fair_rdv", 32'(rd_valid), 32'(1) << prev);
                chk("fair_rdd", 32'(rd_data),  32'(32'h20 + prev));
            end
            prev = seq_a[k];
        end
        set_req(2, 1'b0, 6'h12, 8'h00);
        seq_b = '{0, 1, 2};
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fair2_gnt", 32'(gnt),      32'(1) << seq_b[k]);
            chk("fair2_rdv", 32'(rd_valid), 32'(1) << prev);
            chk("fair2_rdd", 32'(rd_data),  32'(32'h20 + prev));
            prev = seq_b[k];
        end
        req = '0;
        tick();
        chk("fair_last_rdv", 32'(rd_valid), 32'h4);
        chk("fair_last_rdd", 32'(rd_data),  32'h22);

        // Enable toggle: read granted, then en low for 3 cycles with req still up
        set_req(0, 1'b0, 6'h10, 8'h00);
        tick();
        chk("en_gnt", 32'(gnt), 32'h1);
        en = 1'b0;
        tick();
        chk("en0_gnt0",  32'(gnt),      32'h0);
        chk("en0_we0",   32'(mem_we),   32'h0);
        chk("en0_rdv",   32'(rd_valid), 32'h1);
        chk("en0_rdd",   32'(rd_data),  32'h20);
        chk("en0_addr",  32'(mem_addr), 32'h10);
        tick();
        chk("en0_gnt1",  32'(gnt),      32'h0);
        chk("en0_rdv1",  32'(rd_valid), 32'h0);
        tick();
        chk("en0_gnt2",  32'(gnt),      32'h0);
        chk("en0_we2",   32'(mem_we),   32'h0);
        en = 1'b1;
        tick();
        chk("en1_gnt",   32'(gnt),      32'h1);
        req = '0;
        tick();
        chk("en1_rdv",   32'(rd_valid), 32'h1);
        chk("en1_rdd",   32'(rd_data),  32'h20);

        // Reset in the cycle after a read grant drops the return and clears the pointer
        set_req(2, 1'b0, 6'h12, 8'h00);
        tick();
        chk("mr_gnt", 32'(gnt), 32'h4);
        req = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_gnt0",  32'(gnt),      32'h0);
        chk("mr_rdv0",  32'(rd_valid), 32'h0);
        chk("mr_addr0", 32'(mem_addr), 32'h0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("mr_rdv1",  32'(rd_valid), 32'h0);
        chk("mr_gnt1",  32'(gnt),      32'h0);
        tick();
        chk("mr_rdv2",  32'(rd_valid), 32'h0);
        set_req(1, 1'b0, 6'h11, 8'h00);
        set_req(3, 1'b0, 6'h13, 8'h00);
        tick();
        chk("mr_ptr0_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        chk("mr_rdv3", 32'(rd_valid), 32'h2);
        chk("mr_rdd3", 32'(rd_data),  32'h21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
